// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer encodings, response codes, slave FSM states
// and the registered data-phase control.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SZ_BYTE = 3'd0,
    SZ_HALF = 3'd1,
    SZ_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Address-phase control held for the following data phase.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } dphase_t;

endpackage

// File: rtl/ahb_byte_lane_gen.sv
// Little-endian byte-lane enables and alignment check for a 32-bit AHB lane
// group. Sizes above word produce no lanes; the caller flags them separately.
module ahb_byte_lane_gen
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] lane_en,
  output logic       misalign
);

  // decode size/low address into enabled lanes and a misalignment flag
  always_comb begin
    lane_en  = 4'b0000;
    misalign = 1'b0;
    case (hsize_e'(size))
      SZ_BYTE: lane_en = 4'b0001 << addr;
      SZ_HALF: begin
        lane_en  = addr[1] ? 4'b1100 : 4'b0011;
        misalign = addr[0];
      end
      SZ_WORD: begin
        lane_en  = 4'b1111;
        misalign = |addr;
      end
      default: lane_en = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word memory. Legal transfers get WAIT_STATES
// wait cycles then an OKAY completion; illegal ones get the two-cycle ERROR.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned SLV_ID      = 0,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 0
)(
  input  logic        hclk,
  input  logic        hreset,
  input  logic [3:0]  hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(4 * MEM_WORDS);

  slv_state_e  state, state_n;
  logic [2:0]  cnt, cnt_n;
  dphase_t     dp;
  logic        accept, illegal, load, complete, wr_en;
  logic [32:0] ap_off;
  logic        in_range, ap_misalign;
  logic [3:0]  unused_ap_lanes;
  logic [3:0]  dp_lanes;
  logic        unused_dp_misalign;
  logic [31:0] dp_off;
  logic [AW-1:0] widx;
  logic        unused_bits;

  logic [31:0] mem [MEM_WORDS];

  // address phase: decode select/transfer and legality of the access
  assign accept   = hsel[SLV_ID] && hready &&
                    (htrans_e'(htrans) inside {HT_NONSEQ, HT_SEQ});
  // 33-bit offset so addresses below the base show up as a borrow
  assign ap_off   = {1'b0, haddr} - {1'b0, ADDR_BASE};
  assign in_range = !ap_off[32] && (ap_off < SPAN);
  assign illegal  = !in_range || (hsize > 3'(SZ_WORD)) || ap_misalign;

  ahb_byte_lane_gen u_ap_lanes (
    .size     (hsize),
    .addr     (haddr[1:0]),
    .lane_en  (unused_ap_lanes),
    .misalign (ap_misalign)
  );

  // data phase: lanes and word index come from the registered control
  ahb_byte_lane_gen u_dp_lanes (
    .size     (dp.size),
    .addr     (dp.addr[1:0]),
    .lane_en  (dp_lanes),
    .misalign (unused_dp_misalign)
  );

  assign dp_off = dp.addr - ADDR_BASE;
  assign widx   = dp_off[AW+1:2];
  // a reset on the completing edge drops the write
  assign wr_en  = complete && dp.write && !hreset;

  // burst type is informational; other slaves' select bits are not ours
  assign unused_bits = ^{hburst, hsel, dp_off};

  // state register and wait counter
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // capture address-phase control whenever a transfer is accepted
  always_ff @(posedge hclk) begin
    if (hreset) dp <= '0;
    else if (load) dp <= '{addr: haddr, write: hwrite, size: hsize};
  end

  // next state, handshake outputs and completion strobe
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    complete  = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: load = accept;
      ST_DATA: begin
        hreadyout = (cnt == 3'd0);
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
        end else begin
          complete = 1'b1;
          load     = accept;
          state_n  = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_n   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = HRESP_ERROR;
        load    = accept;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    // a pipelined accept overrides the fall-back to IDLE
    if (load) begin
      state_n = illegal ? ST_ERR1 : ST_DATA;
      cnt_n   = 3'(WAIT_STATES);
    end
  end

  // byte-lane write on the completing edge; contents survive reset
  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (dp_lanes[l]) mem[widx][8*l +: 8] <= hwdata[8*l +: 8];
      end
    end
  end

  // read data straight from memory on a completing read, zero otherwise
  always_comb begin
    hrdata = '0;
    if (complete && !dp.write) hrdata = mem[widx];
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench: three slaves (0, 3 and 2 wait states) on one bus, a pipelined master
// driving transfer lists, and a byte-level memory model checked every cycle.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [3:0]  hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic [2:0]  hro, hrs;
  logic [31:0] hrd [3];

  int dp_owner = -1;
  int n_chk = 0, n_pass = 0;

  always #5 hclk = ~hclk;

  // interconnect: bus ready comes from whichever slave owns the data phase
  assign hready = (dp_owner < 0) ? 1'b1 : hro[dp_owner];

  for (genvar g = 0; g < 3; g++) begin : g_slv
    ahb_slave_mem #(
      .SLV_ID      (g),
      .ADDR_BASE   (32'h0),
      .MEM_WORDS   (256),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 2)
    ) u_dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hsel      (hsel),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hburst    (hburst),
      .htrans    (htrans),
      .hwdata    (hwdata),
      .hready    (hready),
      .hreadyout (hro[g]),
      .hresp     (hrs[g]),
      .hrdata    (hrd[g])
    );
  end

  typedef struct {
    int          slv;
    bit          sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  int unsigned ws [3] = '{0, 3, 2};
  logic [31:0] mm [3][256];
  logic [31:0] last_rd;
  xfer_t       q[$];

  function automatic xfer_t mk(int slv, bit wr, logic [31:0] addr,
                               logic [2:0] size, logic [31:0] wdata);
    xfer_t x;
    x.slv = slv; x.sel = 1'b1; x.trans = 2'd2; x.addr = addr;
    x.wr = wr; x.size = size; x.wdata = wdata;
    return x;
  endfunction

  // legality from first principles: 1 KiB window, natural alignment
  function automatic bit legal(xfer_t x);
    if (x.size > 3'd2) return 1'b0;
    if (x.addr >= 32'h400) return 1'b0;
    if ((x.addr % (32'd1 << x.size)) != 0) return 1'b0;
    return 1'b1;
  endfunction

  // each byte address of the transfer lands in lane (address mod 4)
  task automatic model_write(xfer_t x);
    int w;
    w = int'(x.addr >> 2);
    for (int b = 0; b < (1 << x.size); b++) begin
      int a;
      a = int'(x.addr) + b;
      mm[x.slv][w][8*(a%4) +: 8] = x.wdata[8*(a%4) +: 8];
    end
  endtask

  task automatic drive(xfer_t x);
    hsel   = x.sel ? 4'(1 << x.slv) : 4'b0000;
    haddr  = x.addr;
    hwrite = x.wr;
    hsize  = x.size;
    htrans = x.trans;
    hburst = 3'd0;
  endtask

  task automatic drive_idle();
    hsel = 4'b0; htrans = 2'd0; haddr = '0; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0;
  endtask

  // pipelined master: runs everything queued in q, checks each cycle
  task automatic run();
    xfer_t dp;
    bit    have = 1'b0;
    bit    rdy, exp_rdy, exp_rsp;
    logic [31:0] exp_rd;
    int    cyc = 0, i = 0, guard = 0;
    while ((i < q.size() || have) && guard < 20000) begin
      guard++;
      if (i < q.size()) drive(q[i]); else drive_idle();
      dp_owner = have ? dp.slv : -1;
      @(negedge hclk);
      rdy = hready;
      if (have) begin
        if (legal(dp)) begin
          exp_rdy = (cyc == int'(ws[dp.slv]));
          exp_rsp = 1'b0;
        end else begin
          exp_rdy = (cyc == 1);
          exp_rsp = 1'b1;
        end
        exp_rd = (legal(dp) && exp_rdy && !dp.wr) ? mm[dp.slv][dp.addr >> 2] : 32'h0;
        n_chk++;
        if (hro[dp.slv] !== exp_rdy || hrs[dp.slv] !== exp_rsp || hrd[dp.slv] !== exp_rd)
          $display("FAIL dphase slv%0d addr=%h wr=%0d cyc=%0d: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                   dp.slv, dp.addr, dp.wr, cyc, hro[dp.slv], hrs[dp.slv], hrd[dp.slv],
                   exp_rdy, exp_rsp, exp_rd);
        else n_pass++;
        if (exp_rdy && legal(dp) && !dp.wr) last_rd = hrd[dp.slv];
      end
      for (int s = 0; s < 3; s++) begin
        if (!have || s != dp.slv) begin
          n_chk++;
          if (hro[s] !== 1'b1 || hrs[s] !== 1'b0 || hrd[s] !== 32'h0)
            $display("FAIL idle slv%0d: got rdy=%b resp=%b rdata=%h want 1/0/0",
                     s, hro[s], hrs[s], hrd[s]);
          else n_pass++;
        end
      end
      // garbage on hwdata during wait cycles must be ignored
      hwdata = (have && rdy) ? dp.wdata : $urandom();
      @(posedge hclk);
      if (have) begin
        if (rdy) begin
          if (legal(dp) && dp.wr) model_write(dp);
          have = 1'b0;
        end else cyc++;
      end
      if (rdy && i < q.size()) begin
        if (q[i].sel && q[i].trans[1]) begin
          dp = q[i]; have = 1'b1; cyc = 0;
        end
        i++;
      end
      #1;
    end
    if (guard >= 20000) begin
      n_chk++;
      $display("FAIL run timeout: got %0d of %0d transfers issued, want all", i, q.size());
    end
    drive_idle();
    dp_owner = -1;
    q.delete();
  endtask

  task automatic test_reset();
    drive_idle();
    hwdata = '0;
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    for (int s = 0; s < 3; s++) begin
      n_chk++;
      if (hro[s] !== 1'b1 || hrs[s] !== 1'b0 || hrd[s] !== 32'h0)
        $display("FAIL reset slv%0d: got rdy=%b resp=%b rdata=%h want 1/0/0",
                 s, hro[s], hrs[s], hrd[s]);
      else n_pass++;
    end
    @(posedge hclk); #1;
    hreset = 1'b0;
  endtask

  // fill every word of every slave so the model is fully known
  task automatic test_init();
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 256; w++) begin
        xfer_t x;
        x = mk(s, 1'b1, 32'(w * 4), 3'd2, $urandom());
        if (w != 0) x.trans = 2'd3;
        q.push_back(x);
      end
    run();
  endtask

  task automatic test_back_to_back();
    q.push_back(mk(0, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF));
    q.push_back(mk(0, 1'b0, 32'h10, 3'd2, 32'h0));
    run();
    n_chk++;
    if (last_rd !== 32'hDEAD_BEEF)
      $display("FAIL back_to_back: got %h want deadbeef", last_rd);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    logic [31:0] v;
    v = $urandom();
    q.push_back(mk(1, 1'b1, 32'h4, 3'd2, v));
    q.push_back(mk(1, 1'b0, 32'h4, 3'd2, 32'h0));
    q.push_back(mk(2, 1'b0, 32'h4, 3'd2, 32'h0));
    q.push_back(mk(1, 1'b0, 32'h4, 3'd2, 32'h0));
    run();
    n_chk++;
    if (last_rd !== v) $display("FAIL wait_states: got %h want %h", last_rd, v);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    for (int s = 0; s < 3; s++) begin
      q.push_back(mk(s, 1'b1, 32'h20, 3'd2, 32'h1122_3344));
      q.push_back(mk(s, 1'b1, 32'h21, 3'd0, 32'h0000_AA00));
      q.push_back(mk(s, 1'b0, 32'h20, 3'd2, 32'h0));
      run();
      n_chk++;
      if (last_rd !== 32'h1122_AA44) $display("FAIL byte_lane slv%0d: got %h want 1122aa44", s, last_rd);
      else n_pass++;
      q.push_back(mk(s, 1'b1, 32'h22, 3'd1, 32'h5566_0000));
      q.push_back(mk(s, 1'b1, 32'h23, 3'd0, 32'h7700_0000));
      q.push_back(mk(s, 1'b0, 32'h20, 3'd2, 32'h0));
      run();
      n_chk++;
      if (last_rd !== 32'h7766_AA44) $display("FAIL half_lane slv%0d: got %h want 7766aa44", s, last_rd);
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    for (int s = 0; s < 2; s++) begin
      logic [31:0] old0, old8;
      old0 = mm[s][0];
      old8 = mm[s][2];
      q.push_back(mk(s, 1'b1, 32'h3,   3'd1, $urandom()));
      q.push_back(mk(s, 1'b1, 32'h400, 3'd2, $urandom()));
      q.push_back(mk(s, 1'b1, 32'h8,   3'd3, $urandom()));
      q.push_back(mk(s, 1'b1, 32'h2,   3'd2, $urandom()));
      q.push_back(mk(s, 1'b1, 32'h3FC, 3'd2, 32'hCAFE_F00D));
      q.push_back(mk(s, 1'b0, 32'h3FC, 3'd2, 32'h0));
      q.push_back(mk(s, 1'b0, 32'h8,   3'd2, 32'h0));
      run();
      n_chk++;
      if (last_rd !== old8) $display("FAIL err_nowrite8 slv%0d: got %h want %h", s, last_rd, old8);
      else n_pass++;
      q.push_back(mk(s, 1'b0, 32'h0, 3'd2, 32'h0));
      run();
      n_chk++;
      if (last_rd !== old0) $display("FAIL err_nowrite0 slv%0d: got %h want %h", s, last_rd, old0);
      else n_pass++;
    end
  endtask

  task automatic test_unselected();
    xfer_t x;
    logic [31:0] old;
    old = mm[0][0];
    x = mk(0, 1'b1, 32'h0, 3'd2, ~old);
    x.sel = 1'b0;
    q.push_back(x);
    x = mk(0, 1'b1, 32'h0, 3'd2, ~old);
    x.trans = 2'd0;
    q.push_back(x);
    x.trans = 2'd1;
    q.push_back(x);
    q.push_back(mk(0, 1'b0, 32'h0, 3'd2, 32'h0));
    run();
    n_chk++;
    if (last_rd !== old) $display("FAIL unselected: got %h want %h", last_rd, old);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    old = mm[2][12];
    drive(mk(2, 1'b1, 32'h30, 3'd2, ~old));
    @(posedge hclk); #1;
    drive_idle();
    dp_owner = 2;
    hwdata = ~old;
    @(posedge hclk); #1;
    @(negedge hclk);
    n_chk++;
    if (hro[2] !== 1'b0) $display("FAIL reset_mid waiting: got rdy=%b want 0", hro[2]);
    else n_pass++;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    dp_owner = -1;
    @(negedge hclk);
    n_chk++;
    if (hro[2] !== 1'b1 || hrs[2] !== 1'b0 || hrd[2] !== 32'h0)
      $display("FAIL reset_mid outputs: got rdy=%b resp=%b rdata=%h want 1/0/0", hro[2], hrs[2], hrd[2]);
    else n_pass++;
    repeat (3) @(posedge hclk);
    #1;
    q.push_back(mk(2, 1'b0, 32'h30, 3'd2, 32'h0));
    run();
    n_chk++;
    if (last_rd !== old) $display("FAIL reset_mid dropped: got %h want %h", last_rd, old);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      xfer_t x;
      int r;
      x.slv   = int'($urandom_range(0, 2));
      x.sel   = ($urandom_range(0, 9) != 0);
      r       = int'($urandom_range(0, 9));
      x.trans = (r < 1) ? 2'd0 : (r < 2) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
      x.wr    = 1'($urandom_range(0, 1));
      r       = int'($urandom_range(0, 9));
      x.size  = (r == 0) ? 3'd3 : 3'(r % 3);
      x.addr  = $urandom_range(0, 1023);
      if ($urandom_range(0, 7) != 0 && x.size <= 3'd2)
        x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
      if ($urandom_range(0, 15) == 0) x.addr = 32'h400 + $urandom_range(0, 255);
      x.wdata = $urandom();
      q.push_back(x);
    end
    run();
  endtask

  initial begin
    hreset = 1'b0;
    hwdata = '0;
    drive_idle();
    last_rd = '0;
    test_reset();
    test_init();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_unselected();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite responder (slave) with a word-organised register memory. It is the target end of the bus that the team's AHB driver initiates on. It decodes its own select bit, captures address-phase control, and inserts a programmable number of wait states. Writes use byte lanes; reads return data in the data phase; illegal accesses get the two-cycle ERROR response. Used as the DUT-side memory model and as an RTL slave on the team's AHB fabric.

Parameters:
SLV_ID, 0, index into hsel[3:0] that selects this slave (0..3)
ADDR_BASE, 32'h0000_0000, byte base address; must be 4-byte aligned
MEM_WORDS, 256, number of 32-bit words (power of 2, 16..1024)
WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..7)

Ports:
hclk  in  1  bus clock; every register updates on the rising edge
hreset  in  1  synchronous, active-high reset
hsel  in  4  slave selects; this block uses hsel[SLV_ID]
haddr  in  32  address-phase byte address
hwrite  in  1  1=write, 0=read
hsize  in  3  transfer size (0=byte, 1=half, 2=word)
hburst  in  3  burst type; informational only, not checked
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwdata  in  32  write data, valid in the data phase
hready  in  1  bus-level ready; previous data phase completes when high
hreadyout  out  1  this slave's ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  32  read data

Behaviour:
- Reset (synchronous, hreset=1 at an hclk edge):
  - state=IDLE, data-phase valid=0, wait counter=0.
  - hreadyout=1, hresp=0, hrdata=0.
  - Memory contents are not reset.
- Accept condition: hsel[SLV_ID] && hready && htrans[1]. When it holds, the block registers haddr, hwrite and hsize into the data-phase registers at that edge.
- Selected IDLE/BUSY, or hsel[SLV_ID]=0, creates no data phase. The block holds hreadyout=1, hresp=0.
- Error conditions, checked at accept:
  - address outside [ADDR_BASE, ADDR_BASE+4*MEM_WORDS)
  - hsize>2
  - misalignment: hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]!=0
- State machine:
  - IDLE: no data phase pending. On accept go to DATA if the access is legal, else ERR1. DATA loads the wait counter with WAIT_STATES.
  - DATA: hreadyout = (cnt==0); cnt decrements each cycle while >0. On the cycle cnt==0, hresp=0 and the transfer completes:
    - write: the selected byte lanes of hwdata are written to the memory at that edge.
    - read: hrdata = mem[word] (full word, combinational from memory during that cycle).
    - A new accept on that same edge is pipelined: go to DATA/ERR1 again, otherwise to IDLE.
  - ERR1: hreadyout=0, hresp=1, no memory access. Always go to ERR2.
  - ERR2: hreadyout=1, hresp=1. A new accept here is captured as in DATA completion. The master may instead drive IDLE.
- Byte lanes are little-endian, derived from the registered size and address:
  - byte: lane = addr[1:0]
  - half: lanes {addr[1],0} and {addr[1],1}
  - word: all 4 lanes
- Read-after-write: a write completing at edge N is visible to a read data phase at cycle N+1. No forwarding path is needed because the read is combinational from memory.
- hrdata=0 whenever the cycle is not a completing read.
- Write data is sampled only on the completing edge. hwdata during wait cycles is ignored.
- Word index = (addr-ADDR_BASE)>>2, truncated to log2(MEM_WORDS) bits.
- Reset mid-transfer: the pending write is dropped, and outputs take reset values on the next cycle.
- hready low from another slave: no accept occurs, and this block's DATA/ERR state is unaffected (it cannot be in a data phase then).

Decomposition:
- ahb_pkg contains:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ)
  - hsize_e (BYTE/HALF/WORD)
  - hresp constants OKAY/ERROR
  - slave state enum (IDLE/DATA/ERR1/ERR2)
- Sub-module ahb_byte_lane_gen: combinational size plus addr[1:0] to 4-bit lane enable and misalign flag. It is reused by other AHB slaves.

Test Plan:
1. Reset with hreset=1 for 2 cycles -> hreadyout=1, hresp=0, hrdata=0.
2. WAIT_STATES=0, word write 32'hDEAD_BEEF @0x10, then read @0x10 back-to-back -> read completes with no wait state, hrdata=32'hDEAD_BEEF, hresp=0.
3. WAIT_STATES=3, read @0x4 -> hreadyout low 3 cycles then high; data is correct on the 4th data-phase cycle.
4. Word write 0x1122_3344 @0x20, then byte write 0xAA @0x21 (hwdata=32'h0000_AA00), then word read @0x20 -> 32'h1122_AA44.
5. Unaligned access (half @0x3) and out-of-range access (0x400 with MEM_WORDS=256) -> each gives hreadyout=0/hresp=1, then hreadyout=1/hresp=1, and memory is unchanged.
6. hsel[SLV_ID]=0 with NONSEQ write @0x0, then read @0x0 with hsel set -> the old value returns (no write occurred). Also assert hreset during a WAIT_STATES=2 write -> the write is dropped.
